lsu_reduce_engine: RTL
======================

LSU_REDUCE_ENGINE -- requirements
Module: lsu_reduce_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 22, word-address width.
REQ-003 SHALL have parameter LANE_W, default 8, lane width; DATA_W SHALL be a multiple of LANE_W; LANES = DATA_W/LANE_W.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of two, >=2), result buffer depth.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1  begin job (pulse).
REQ-008 SHALL have port done  out  1  one-cycle pulse at job end.
REQ-009 SHALL have port busy  out  1  job in progress.
REQ-010 SHALL have port op  in  2  reduction: 00 sum, 01 saturating sum, 10 max lane, 11 min lane.
REQ-011 SHALL have ports load_base_addr, store_base_addr, count  in  ADDR_W each  job configuration.
REQ-012 SHALL have ports load_stride, store_stride  in  ADDR_W each  address increment per element.
REQ-013 SHALL have ports load_req out 1, load_addr out ADDR_W, load_data in DATA_W, load_complete in 1  load channel.
REQ-014 SHALL have ports store_req out 1, store_addr out ADDR_W, store_data out DATA_W, store_complete in 1  store channel.

Function
REQ-015 SHALL latch op, bases, strides and count on the clk edge where start=1 and busy=0; start while busy=1 is ignored.
REQ-016 SHALL assert busy from the cycle after an accepted start until the cycle done pulses, inclusive.
REQ-017 Load side SHALL assert load_req while loads issued < count and (FIFO occupancy + outstanding load) < FIFO_DEPTH; at most one load outstanding.
REQ-018 load_addr SHALL equal load_base_addr + i*load_stride mod 2^ADDR_W for element i, held stable while load_req=1.
REQ-019 On an edge with load_req=1 and load_complete=1, SHALL capture load_data, reduce it and push the result into the FIFO at that same edge; load_req SHALL drop for at least the following cycle; load_complete with load_req=0 SHALL be ignored.
REQ-020 Sum: zero-extended sum of all LANES unsigned lanes, width LANE_W+clog2(LANES) (10 bits at defaults), zero-extended to DATA_W.
REQ-021 Saturating sum: sum clamped to 2^LANE_W-1; max/min: largest/smallest unsigned lane; all zero-extended to DATA_W.
REQ-022 Store side SHALL assert store_req whenever the FIFO is non-empty and a job is active, with store_data = FIFO head and store_addr = store_base_addr + j*store_stride mod 2^ADDR_W for element j.
REQ-023 On an edge with store_req=1 and store_complete=1, SHALL pop the head and increment j; store_req SHALL drop for at least the following cycle.
REQ-024 Push and pop on the same edge SHALL leave occupancy unchanged; FIFO SHALL never overflow or underflow; pointers wrap modulo FIFO_DEPTH.
REQ-025 done SHALL pulse for one cycle on the cycle after the count-th store completes, then busy=0 and the block returns to idle.
REQ-026 count=0 SHALL produce done one cycle after start with no load_req or store_req.
REQ-027 Load and store channels SHALL operate concurrently (load of element i+1 may overlap store of element i).

Reset
REQ-028 reset_n=0 SHALL immediately force done, busy, load_req, store_req to 0, load_addr, store_addr, store_data to 0, clear FIFO and counters, including mid-job; job is abandoned, no done issued.
REQ-029 After reset_n deasserts, the block SHALL accept start on the next rising edge.

Verification
REQ-030 Sum job: load_base=0x0, store_base=0x10, strides=1, count=4, words 0x01020000, 0x01010101, 0xFFFFFFFF, 0x80808080 -> stores 0x003, 0x004, 0x3FC, 0x200 to 0x10..0x13, then one done pulse.
REQ-031 Modes on word 0xFFFFFFFF / 0x80017F02: op=01 -> 0xFF / 0xFF; op=10 -> 0xFF / 0x80; op=11 -> 0xFF / 0x01.
REQ-032 Backpressure: count=8, store_complete withheld for 20 cycles -> exactly FIFO_DEPTH loads complete, load_req low thereafter, all 8 stores correct in order once released.
REQ-033 Strides/wrap: load_base=0x3FFFFE, load_stride=2, count=3 -> load_addr sequence 0x3FFFFE, 0x000000, 0x000002.
REQ-034 count=0 -> done one cycle after start, no requests; start asserted while busy -> ignored, original job completes unchanged.
REQ-035 reset_n pulsed low after 2 of 4 stores -> all outputs 0 at once, no done; new start then runs a full correct job.

Source files
------------

// File: rtl/lsu_reduce_engine.sv
`default_nettype none
// ============================================================================
// Module  : lsu_reduce_engine
// Brief   : Strided load -> per-word lane reduction -> buffered strided store.
// Revision: 1.0  initial release
// ============================================================================
module lsu_reduce_engine #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 22,
    parameter int LANE_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              done,
    output logic              busy,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] load_base_addr,
    input  logic [ADDR_W-1:0] store_base_addr,
    input  logic [ADDR_W-1:0] count,
    input  logic [ADDR_W-1:0] load_stride,
    input  logic [ADDR_W-1:0] store_stride,
    output logic              load_req,
    output logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_complete,
    output logic              store_req,
    output logic [ADDR_W-1:0] store_addr,
    output logic [DATA_W-1:0] store_data,
    input  logic              store_complete
);

    localparam int c_LANES = DATA_W / LANE_W;
    localparam int c_SUM_W = LANE_W + $clog2(c_LANES);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_count;
    logic [ADDR_W-1:0]   r_load_stride;
    logic [ADDR_W-1:0]   r_store_stride;
    logic [ADDR_W-1:0]   r_load_addr;
    logic [ADDR_W-1:0]   r_store_addr;
    logic [ADDR_W-1:0]   r_load_cnt;
    logic [ADDR_W-1:0]   r_store_cnt;
    logic                r_load_req;
    logic                r_store_req;
    logic                w_load_req_nxt;
    logic                w_store_req_nxt;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_OCC_W-1:0]  r_occ;
    logic [c_OCC_W-1:0]  w_occ_nxt;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];

    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_store_last;
    logic [LANE_W-1:0]   w_lane;
    logic [c_SUM_W-1:0]  w_sum;
    logic [c_SUM_W-1:0]  w_sat_max;
    logic [LANE_W-1:0]   w_max;
    logic [LANE_W-1:0]   w_min;
    logic [DATA_W-1:0]   w_result;

    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_push       = r_load_req && load_complete;
    assign w_pop        = r_store_req && store_complete;
    assign w_occ_nxt    = r_occ + c_OCC_W'(w_push) - c_OCC_W'(w_pop);
    assign w_store_last = w_pop && ((r_store_cnt + ADDR_W'(1)) == r_count);

    always_comb begin
        w_sum     = '0;
        w_max     = '0;
        w_min     = '1;
        w_lane    = '0;
        w_sat_max = '0;
        w_sat_max[LANE_W-1:0] = '1;
        for (int k = 0; k < c_LANES; k++) begin
            w_lane = load_data[k*LANE_W +: LANE_W];
            w_sum  = w_sum + c_SUM_W'(w_lane);
            if (w_lane > w_max) w_max = w_lane;
            if (w_lane < w_min) w_min = w_lane;
        end
        w_result = '0;
        case (r_op)
            2'b00:   w_result[c_SUM_W-1:0] = w_sum;
            2'b01:   w_result[c_SUM_W-1:0] = (w_sum > w_sat_max) ? w_sat_max : w_sum;
            2'b10:   w_result[LANE_W-1:0]  = w_max;
            default: w_result[LANE_W-1:0]  = w_min;
        endcase
    end

    // Requests drop for one cycle after each handshake; load issue is gated on
    // buffer room as it will be after this edge's push/pop.
    always_comb begin
        w_state_nxt     = r_state;
        w_load_req_nxt  = 1'b0;
        w_store_req_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = (count == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (r_load_req) w_load_req_nxt = !load_complete;
                else            w_load_req_nxt = (r_load_cnt < r_count) &&
                                                 (w_occ_nxt < c_OCC_W'(FIFO_DEPTH));
                if (r_store_req) w_store_req_nxt = !store_complete;
                else             w_store_req_nxt = (w_occ_nxt != '0);
                if (w_store_last) begin
                    w_state_nxt     = S_DONE;
                    w_store_req_nxt = 1'b0;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_op           <= '0;
            r_count        <= '0;
            r_load_stride  <= '0;
            r_store_stride <= '0;
            r_load_addr    <= '0;
            r_store_addr   <= '0;
            r_load_cnt     <= '0;
            r_store_cnt    <= '0;
            r_load_req     <= 1'b0;
            r_store_req    <= 1'b0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_occ          <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_load_req  <= w_load_req_nxt;
            r_store_req <= w_store_req_nxt;
            if (w_accept) begin
                r_op           <= op;
                r_count        <= count;
                r_load_stride  <= load_stride;
                r_store_stride <= store_stride;
                r_load_addr    <= load_base_addr;
                r_store_addr   <= store_base_addr;
                r_load_cnt     <= '0;
                r_store_cnt    <= '0;
                r_wr_ptr       <= '0;
                r_rd_ptr       <= '0;
                r_occ          <= '0;
            end else begin
                r_occ <= w_occ_nxt;
                if (w_push) begin
                    r_load_addr <= r_load_addr + r_load_stride;
                    r_load_cnt  <= r_load_cnt + ADDR_W'(1);
                    r_wr_ptr    <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_store_addr <= r_store_addr + r_store_stride;
                    r_store_cnt  <= r_store_cnt + ADDR_W'(1);
                    r_rd_ptr     <= r_rd_ptr + c_PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_result;
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign load_req   = r_load_req;
    assign load_addr  = r_load_addr;
    assign store_req  = r_store_req;
    assign store_addr = r_store_addr;
    assign store_data = r_store_req ? r_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire
